// File: rtl/aemb_iwb_pkg.sv
// Shared definitions for the AEMB instruction-side Wishbone memory.
//   iwb_state_e : responder FSM state encoding
//   WCNT_W      : width of the wait-state counter (WS up to 15)
package aemb_iwb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_ACK  = 2'd3
  } iwb_state_e;

  localparam int WCNT_W = 4;

endpackage

// File: rtl/aemb_iwb_ram.sv
// Single-port synchronous RAM, 2**AW x 32.
//   gclk  : clock
//   i_we  : write enable (the caller gives writes priority on i_adr)
//   i_re  : read enable; o_dat updates only on a read, otherwise holds
//   i_adr : shared word address
//   i_dat : write data
//   o_dat : registered read data (read-before-write on a shared address)
module aemb_iwb_ram #(
  parameter int AW = 10
) (
  input  logic          gclk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_adr,
  input  logic [31:0]   i_dat,
  output logic [31:0]   o_dat
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_q;

  // r_q only moves on a read, so a pending word survives later writes.
  always_ff @(posedge gclk) begin
    if (i_re) r_q <= r_mem[i_adr];
    if (i_we) r_mem[i_adr] <= i_dat;
  end

  assign o_dat = r_q;

endmodule

// File: rtl/aemb_iwb_mem.sv
// Instruction-side Wishbone responder for the AEMB core, backed by on-chip RAM
// with WS programmable wait states and a separate program-load port.
//   gclk, grst          : clock, synchronous active-high reset
//   iwb_adr_i/iwb_stb_i : word address [IW-1:2] and request strobe
//   iwb_ack_o           : one-cycle acknowledge per completed read
//   iwb_dat_o           : instruction word, held between acks
//   ld_we_i/adr/dat     : load-port write (wins the RAM port over a new read)
module aemb_iwb_mem
  import aemb_iwb_pkg::*;
#(
  parameter int IW = 24,
  parameter int AW = 10,
  parameter int WS = 0
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic [IW-1:2] iwb_adr_i,
  input  logic          iwb_stb_i,
  output logic          iwb_ack_o,
  output logic [31:0]   iwb_dat_o,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_adr_i,
  input  logic [31:0]   ld_dat_i
);

  localparam logic [WCNT_W-1:0] WS_LD = (WS > 0) ? WCNT_W'(WS - 1) : '0;

  iwb_state_e        r_state, w_nxt;
  logic [WCNT_W-1:0] r_cnt;
  logic [AW-1:0]     r_adr;
  logic              r_ack;
  logic [31:0]       r_dat;

  logic              w_issue, w_cap, w_ld_cnt;
  logic [AW-1:0]     w_ram_adr;
  logic [31:0]       w_ram_q;
  logic              w_unused_adr;

  // Upper address bits are ignored: the RAM wraps modulo 2**AW.
  assign w_unused_adr = ^iwb_adr_i[IW-1:AW+2];

  assign w_issue = (r_state == S_IDLE) && iwb_stb_i && !ld_we_i;

  // Load writes own the port; otherwise present the new or latched address.
  assign w_ram_adr = ld_we_i ? ld_adr_i :
                     w_issue ? iwb_adr_i[AW+1:2] : r_adr;

  aemb_iwb_ram #(.AW(AW)) u_ram (
    .gclk  (gclk),
    .i_we  (ld_we_i),
    .i_re  (w_issue),
    .i_adr (w_ram_adr),
    .i_dat (ld_dat_i),
    .o_dat (w_ram_q)
  );

  always_comb begin
    w_nxt    = r_state;
    w_cap    = 1'b0;
    w_ld_cnt = 1'b0;
    case (r_state)
      S_IDLE: if (w_issue) w_nxt = S_READ;
      S_READ: begin
        if (!iwb_stb_i) w_nxt = S_IDLE;
        else if (WS == 0) begin
          w_cap = 1'b1;
          w_nxt = S_ACK;
        end else begin
          w_ld_cnt = 1'b1;
          w_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!iwb_stb_i) w_nxt = S_IDLE;
        else if (r_cnt == '0) begin
          w_cap = 1'b1;
          w_nxt = S_ACK;
        end
      end
      S_ACK:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // The ack is registered out of S_ACK, so it appears WS+2 edges after the
  // strobe is taken; the master re-arms only after seeing it.
  always_ff @(posedge gclk) begin
    if (grst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_nxt;
      r_ack   <= (r_state == S_ACK);
      if (w_issue) r_adr <= iwb_adr_i[AW+1:2];
      if (w_ld_cnt) r_cnt <= WS_LD;
      else if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_cap) r_dat <= w_ram_q;
    end
  end

  assign iwb_ack_o = r_ack;
  assign iwb_dat_o = r_dat;

endmodule

// File: tb/tb_aemb_iwb_mem.sv
module tb_aemb_iwb_mem;

  localparam int WSV [3] = '{0, 3, 4};

  logic        gclk = 1'b0;
  logic        grst = 1'b1;
  logic        ld_we = 1'b0;
  logic [9:0]  ld_adr = '0;
  logic [31:0] ld_dat = '0;
  logic        stb [3];
  logic [21:0] adr [3];
  logic        ack [3];
  logic [31:0] dat [3];

  logic [31:0] model [1024];
  logic [31:0] last_dat [3];
  int errors = 0;
  int checks = 0;

  always #5 gclk = ~gclk;

  aemb_iwb_mem #(.IW(24), .AW(10), .WS(0)) u_ws0 (
    .gclk(gclk), .grst(grst), .iwb_adr_i(adr[0]), .iwb_stb_i(stb[0]),
    .iwb_ack_o(ack[0]), .iwb_dat_o(dat[0]),
    .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat));
  aemb_iwb_mem #(.IW(24), .AW(10), .WS(3)) u_ws3 (
    .gclk(gclk), .grst(grst), .iwb_adr_i(adr[1]), .iwb_stb_i(stb[1]),
    .iwb_ack_o(ack[1]), .iwb_dat_o(dat[1]),
    .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat));
  aemb_iwb_mem #(.IW(24), .AW(10), .WS(4)) u_ws4 (
    .gclk(gclk), .grst(grst), .iwb_adr_i(adr[2]), .iwb_stb_i(stb[2]),
    .iwb_ack_o(ack[2]), .iwb_dat_o(dat[2]),
    .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat));

  task automatic ld(input logic [9:0] a, input logic [31:0] d);
    @(negedge gclk); ld_we = 1'b1; ld_adr = a; ld_dat = d;
    @(negedge gclk); ld_we = 1'b0;
    model[a] = d;
  endtask

  // One read on instance k; optionally overwrite the same word while pending.
  task automatic do_read(input int k, input logic [21:0] a, input bit mid_wr, input string nm);
    logic [31:0] exp;
    int n;
    bit got;
    @(negedge gclk); stb[k] = 1'b1; adr[k] = a;
    exp = model[a[9:0]];
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge gclk); n++;
      @(negedge gclk);
      if (mid_wr && n == 1) begin ld_we = 1'b1; ld_adr = a[9:0]; ld_dat = $urandom; end
      if (mid_wr && n == 2) begin ld_we = 1'b0; model[a[9:0]] = ld_dat; end
      if (ack[k]) got = 1;
    end
    stb[k] = 1'b0; ld_we = 1'b0;
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s timeout: no ack after %0d cycles", nm, n);
    end else begin
      checks++;
      if (n - 1 !== WSV[k] + 2) begin
        errors++; $display("FAIL %s latency: got %0d want %0d", nm, n - 1, WSV[k] + 2);
      end
      checks++;
      if (dat[k] !== exp) begin
        errors++; $display("FAIL %s data: got %h want %h", nm, dat[k], exp);
      end
      last_dat[k] = exp;
      @(negedge gclk);
      checks++;
      if (ack[k] !== 1'b0) begin
        errors++; $display("FAIL %s ack_pulse: got %b want 0", nm, ack[k]);
      end
    end
  endtask

  task automatic count_acks(input int k, input int cyc, output int cnt);
    cnt = 0;
    repeat (cyc) begin
      @(negedge gclk);
      if (ack[k]) cnt++;
    end
  endtask

  task automatic test_reset();
    grst = 1'b1;
    repeat (3) @(negedge gclk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ack[k] !== 1'b0 || dat[k] !== 32'h0) begin
        errors++; $display("FAIL reset[%0d]: ack=%b dat=%h want ack=0 dat=0", k, ack[k], dat[k]);
      end
      last_dat[k] = 32'h0;
    end
    grst = 1'b0;
  endtask

  task automatic test_load_read();
    ld(10'd5, 32'hB800_0010);
    do_read(0, 22'd5, 0, "load_read_ws0");
    checks++;
    if (last_dat[0] !== 32'hB800_0010) begin
      errors++; $display("FAIL load_read_const: got %h want b8000010", dat[0]);
    end
  endtask

  task automatic test_back_to_back(input int k, input logic [21:0] a, input logic [21:0] b);
    logic [31:0] e1, e2;
    int n;
    bit got;
    e1 = model[a[9:0]]; e2 = model[b[9:0]];
    @(negedge gclk); stb[k] = 1'b1; adr[k] = a;
    n = 0; got = 0;
    while (!got && n < 40) begin @(posedge gclk); n++; @(negedge gclk); got = ack[k]; end
    checks++;
    if (!got || dat[k] !== e1) begin
      errors++; $display("FAIL b2b_first: got=%b dat=%h want %h", got, dat[k], e1);
    end
    adr[k] = b;
    n = 0; got = 0;
    while (!got && n < 40) begin @(posedge gclk); n++; @(negedge gclk); got = ack[k]; end
    stb[k] = 1'b0;
    checks++;
    if (!got || n !== WSV[k] + 3) begin
      errors++; $display("FAIL b2b_period: got %0d cycles want %0d", n, WSV[k] + 3);
    end
    checks++;
    if (dat[k] !== e2) begin
      errors++; $display("FAIL b2b_second: got %h want %h", dat[k], e2);
    end
    last_dat[k] = e2;
    @(negedge gclk);
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 4; i++) ld(10'(i), $urandom);
    do_read(1, 22'd2, 0, "ws3_read");
    test_back_to_back(1, 22'd1, 22'd3);
    do_read(1, 22'd2, 1, "ws3_write_pending");
    do_read(1, 22'd2, 0, "ws3_after_write");
  endtask

  task automatic test_abort();
    int cnt;
    ld(10'd1, 32'hCAFE_0001);
    @(negedge gclk); stb[2] = 1'b1; adr[2] = 22'd3;
    repeat (3) @(posedge gclk);
    @(negedge gclk); stb[2] = 1'b0;
    count_acks(2, 12, cnt);
    checks++;
    if (cnt !== 0) begin
      errors++; $display("FAIL abort_no_ack: got %0d acks want 0", cnt);
    end
    checks++;
    if (dat[2] !== last_dat[2]) begin
      errors++; $display("FAIL abort_dat_hold: got %h want %h", dat[2], last_dat[2]);
    end
    do_read(2, 22'd1, 0, "abort_then_read");
  endtask

  task automatic test_collision();
    int n;
    bit got;
    @(negedge gclk);
    ld_we = 1'b1; ld_adr = 10'd7; ld_dat = 32'h1234_5678;
    stb[0] = 1'b1; adr[0] = 22'd7;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge gclk); n++;
      @(negedge gclk);
      if (n == 1) begin ld_we = 1'b0; model[7] = 32'h1234_5678; end
      got = ack[0];
    end
    stb[0] = 1'b0;
    checks++;
    if (!got || n - 1 !== 3) begin
      errors++; $display("FAIL collision_latency: got %0d want 3", n - 1);
    end
    checks++;
    if (dat[0] !== 32'h1234_5678) begin
      errors++; $display("FAIL collision_data: got %h want 12345678", dat[0]);
    end
    last_dat[0] = 32'h1234_5678;
    @(negedge gclk);
  endtask

  task automatic test_wrap();
    ld(10'h3FF, 32'hDEAD_03FF);
    do_read(0, 22'h3FF + 22'd1024, 0, "wrap_ws0");
    do_read(2, 22'h3F_FFFF, 0, "wrap_ws4_top");
  endtask

  task automatic test_reset_midop();
    int cnt;
    @(negedge gclk); stb[1] = 1'b1; adr[1] = 22'd2;
    repeat (2) @(posedge gclk);
    @(negedge gclk); grst = 1'b1; stb[1] = 1'b0;
    @(negedge gclk);
    checks++;
    if (ack[1] !== 1'b0 || dat[1] !== 32'h0) begin
      errors++; $display("FAIL reset_midop: ack=%b dat=%h want 0/0", ack[1], dat[1]);
    end
    grst = 1'b0;
    for (int k = 0; k < 3; k++) last_dat[k] = 32'h0;
    count_acks(1, 10, cnt);
    checks++;
    if (cnt !== 0) begin
      errors++; $display("FAIL reset_no_ack: got %0d acks want 0", cnt);
    end
    do_read(1, 22'd2, 0, "post_reset_read");
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) ld(10'($urandom), $urandom);
      r = $urandom;
      do_read($urandom_range(0, 2), r[21:0], $urandom_range(0, 3) == 0, "random");
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin stb[k] = 1'b0; adr[k] = '0; last_dat[k] = '0; end
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    for (int i = 0; i < 1024; i++) ld(10'(i), $urandom);
    test_reset();
    test_load_read();
    test_wait_states();
    test_abort();
    test_collision();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
